// File: rtl/user_popcnt_acc_pkg.sv
// Shared definitions for the set-bit accumulator.
// Contents:
//   - OBI default request/response structs. The address is 32 bits, the data
//     is 32 bits and the ID is 4 bits.
//   - Register byte offsets and CTRL bit indices.
//   - The popcount engine state enum.
package user_popcnt_acc_pkg;

  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;
  localparam int unsigned ObiIdWidth   = 4;

  typedef struct packed {
    logic [ObiAddrWidth-1:0]   addr;
    logic                      we;
    logic [ObiDataWidth/8-1:0] be;
    logic [ObiDataWidth-1:0]   wdata;
    logic [ObiIdWidth-1:0]     aid;
  } obi_default_a_chan_t;

  typedef struct packed {
    logic                req;
    obi_default_a_chan_t a;
  } obi_default_req_t;

  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic [ObiIdWidth-1:0]   rid;
    logic                    err;
  } obi_default_r_chan_t;

  typedef struct packed {
    logic                gnt;
    logic                rvalid;
    obi_default_r_chan_t r;
  } obi_default_rsp_t;

  // Register byte offsets. Channel c owns ADD at ChanBase + ChanStride*c and
  // ACC at the next word.
  localparam logic [7:0] CtrlOffs   = 8'h00;
  localparam logic [7:0] ClearOffs  = 8'h04;
  localparam logic [7:0] OvfOffs    = 8'h08;
  localparam logic [7:0] ChanBase   = 8'h10;
  localparam logic [7:0] ChanStride = 8'h08;

  localparam int unsigned CtrlSatEnBit = 0;
  localparam int unsigned CtrlBusyBit  = 1;

  typedef enum logic {
    EngIdle  = 1'b0,
    EngCount = 1'b1
  } eng_state_e;

endpackage

// File: rtl/user_popcnt_chunk.sv
// Combinational popcount of one ChunkBits-wide slice.
// Ports:
//   chunk_i : ChunkBits-wide input vector.
//   count_o : number of set bits in chunk_i, $clog2(ChunkBits+1) bits wide.
module user_popcnt_chunk #(
  parameter int unsigned ChunkBits = 8,
  localparam int unsigned CntW     = $clog2(ChunkBits + 1)
) (
  input  logic [ChunkBits-1:0] chunk_i,
  output logic [CntW-1:0]      count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < ChunkBits; i++) begin
      count_o = count_o + CntW'(chunk_i[i]);
    end
  end

endmodule

// File: rtl/user_popcnt_acc.sv
// Multi-channel set-bit accumulator behind an OBI subordinate port.
//
// A write to ADD[c] latches the write data. The engine then counts the set
// bits, ChunkBits per cycle, LSB chunk first. The total is added to ACC[c],
// with wrap or saturate behaviour and a sticky per-channel overflow flag.
// While the engine runs, gnt is held low for every access, reads included.
// That single stall keeps register reads coherent. It also means an engine
// update and a register write can never fall in the same cycle.
//
// Ports:
//   clk_i     : clock.
//   rst_ni    : synchronous active-low reset.
//   obi_req_i : OBI request (req, addr, we, be, wdata, aid). The byte enables
//               are ignored. Every write is treated as a full-word write.
//   obi_rsp_o : OBI response. gnt is combinational. rvalid, rdata, rid and err
//               are registered and appear one cycle after the handshake.
module user_popcnt_acc
  import user_popcnt_acc_pkg::*;
#(
  parameter int unsigned DataWidth   = ObiDataWidth,
  parameter int unsigned NumChannels = 4,
  parameter int unsigned AccWidth    = 16,
  parameter int unsigned ChunkBits   = 8,
  parameter type         obi_req_t   = obi_default_req_t,
  parameter type         obi_rsp_t   = obi_default_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o
);

  localparam int unsigned NumChunks = DataWidth / ChunkBits;
  localparam int unsigned PartW     = $clog2(DataWidth + 1);
  localparam int unsigned PcW       = $clog2(ChunkBits + 1);
  localparam int unsigned ChW       = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int unsigned IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int unsigned SumW      = ((AccWidth > PartW) ? AccWidth : PartW) + 1;
  localparam int unsigned ChanWords = 2 * NumChannels;

  eng_state_e             state_q, state_d;
  logic [DataWidth-1:0]   data_q, data_d;
  logic [ChW-1:0]         chan_q, chan_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [PartW-1:0]       part_q, part_d;
  logic [AccWidth-1:0]    acc_q [NumChannels];
  logic [AccWidth-1:0]    acc_d [NumChannels];
  logic [NumChannels-1:0] ovf_q, ovf_d;
  logic                   sat_en_q, sat_en_d;
  logic                   rvalid_q, rvalid_d;
  logic                   err_q, err_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic [ObiIdWidth-1:0]  rid_q, rid_d;

  // Decode on word granularity. addr[1:0] and addr[31:8] do not select anything.
  logic [5:0]     word;
  logic [5:0]     chan_word;
  logic [ChW-1:0] dec_chan;
  logic           is_ctrl, is_clear, is_ovf, in_chan, acc_sel, dec_err, hs;
  logic [PcW-1:0] pc_cnt;
  logic [PartW-1:0] part_total;
  logic [SumW-1:0]  sum;

  assign word      = obi_req_i.a.addr[7:2];
  assign chan_word = word - ChanBase[7:2];
  assign dec_chan  = chan_word[ChW:1];
  assign acc_sel   = chan_word[0];
  assign is_ctrl   = (word == CtrlOffs[7:2]);
  assign is_clear  = (word == ClearOffs[7:2]);
  assign is_ovf    = (word == OvfOffs[7:2]);
  assign in_chan   = (word >= ChanBase[7:2]) && ({26'd0, chan_word} < ChanWords);

  // Error cases:
  //   - the hole at 0x0C;
  //   - anything past the last channel;
  //   - reads of the write-only CLEAR and ADD registers.
  assign dec_err = (!is_ctrl && !is_clear && !is_ovf && !in_chan) ||
                   (!obi_req_i.a.we && (is_clear || (in_chan && !acc_sel)));

  assign hs = obi_req_i.req && (state_q == EngIdle);

  logic unused_bits;
  assign unused_bits = ^{obi_req_i.a.addr[31:8], obi_req_i.a.addr[1:0], obi_req_i.a.be};

  // The engine always counts the low chunk. data_q shifts right as it goes.
  user_popcnt_chunk #(.ChunkBits(ChunkBits)) u_chunk (
    .chunk_i (data_q[ChunkBits-1:0]),
    .count_o (pc_cnt)
  );

  assign part_total = part_q + PartW'(pc_cnt);
  assign sum        = SumW'(acc_q[chan_q]) + SumW'(part_total);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    chan_d   = chan_q;
    idx_d    = idx_q;
    part_d   = part_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    sat_en_d = sat_en_q;
    rvalid_d = hs;
    err_d    = hs && dec_err;
    rid_d    = hs ? obi_req_i.a.aid : '0;
    rdata_d  = '0;

    if (hs && !dec_err) begin
      if (obi_req_i.a.we) begin
        if (is_ctrl) begin
          sat_en_d = obi_req_i.a.wdata[CtrlSatEnBit];
        end else if (is_clear) begin
          for (int c = 0; c < NumChannels; c++) begin
            if (obi_req_i.a.wdata[c]) begin
              acc_d[c] = '0;
              ovf_d[c] = 1'b0;
            end
          end
        end else if (is_ovf) begin
          ovf_d = ovf_q & ~obi_req_i.a.wdata[NumChannels-1:0];
        end else if (acc_sel) begin
          acc_d[dec_chan] = obi_req_i.a.wdata[AccWidth-1:0];
        end else begin
          state_d = EngCount;
          data_d  = obi_req_i.a.wdata[DataWidth-1:0];
          chan_d  = dec_chan;
          idx_d   = '0;
          part_d  = '0;
        end
      end else begin
        if (is_ctrl) begin
          rdata_d[CtrlSatEnBit] = sat_en_q;
          rdata_d[CtrlBusyBit]  = 1'b0;
        end else if (is_ovf) begin
          rdata_d[NumChannels-1:0] = ovf_q;
        end else begin
          rdata_d[AccWidth-1:0] = acc_q[dec_chan];
        end
      end
    end

    if (state_q == EngCount) begin
      data_d = data_q >> ChunkBits;
      part_d = part_total;
      idx_d  = idx_q + 1'b1;
      if (idx_q == IdxW'(NumChunks - 1)) begin
        state_d = EngIdle;
        // The carry bits above AccWidth flag overflow. Saturation is decided
        // by sat_en as it stands at this cycle, not at launch.
        if (sum[SumW-1:AccWidth] != '0) begin
          ovf_d[chan_q] = 1'b1;
          acc_d[chan_q] = sat_en_q ? '1 : sum[AccWidth-1:0];
        end else begin
          acc_d[chan_q] = sum[AccWidth-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= EngIdle;
      data_q   <= '0;
      chan_q   <= '0;
      idx_q    <= '0;
      part_q   <= '0;
      ovf_q    <= '0;
      sat_en_q <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      chan_q   <= chan_d;
      idx_q    <= idx_d;
      part_q   <= part_d;
      ovf_q    <= ovf_d;
      sat_en_q <= sat_en_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rid_q    <= rid_d;
    end
  end

  for (genvar gi = 0; gi < NumChannels; gi++) begin : g_acc
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        acc_q[gi] <= '0;
      end else begin
        acc_q[gi] <= acc_d[gi];
      end
    end
  end

  always_comb begin
    obi_rsp_o          = '0;
    obi_rsp_o.gnt      = hs;
    obi_rsp_o.rvalid   = rvalid_q;
    obi_rsp_o.r.rdata  = rdata_q;
    obi_rsp_o.r.rid    = rid_q;
    obi_rsp_o.r.err    = err_q;
  end

endmodule

// File: tb/tb_user_popcnt_acc.sv
// Directed bench for user_popcnt_acc. Expected responses are queued when a
// request is driven and popped when rvalid comes back.
module tb_user_popcnt_acc;
  import user_popcnt_acc_pkg::*;

  typedef struct {
    logic [7:0]  off;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  rid;
    bit          chk_rdata;
  } exp_t;

  logic             clk;
  logic             rst_n;
  obi_default_req_t obi_req;
  obi_default_rsp_t obi_rsp;

  exp_t sb[$];
  int   total_cnt;
  int   pass_cnt;
  int   fail_cnt;
  logic [3:0] aid_ctr;

  user_popcnt_acc #(
    .NumChannels (4),
    .AccWidth    (16),
    .ChunkBits   (8)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .obi_req_i (obi_req),
    .obi_rsp_o (obi_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge. Drives one access, waits a bounded time for gnt,
  // then checks the response at the following negedge.
  task automatic access(input logic we, input logic [7:0] off, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_waits);
    exp_t e;
    int   waits;
    logic [3:0] aid;
    aid = aid_ctr;
    aid_ctr = aid_ctr + 4'd1;
    obi_req.req     = 1'b1;
    obi_req.a.we    = we;
    obi_req.a.addr  = {24'd0, off};
    obi_req.a.be    = 4'hF;
    obi_req.a.wdata = we ? wdata : 32'd0;
    obi_req.a.aid   = aid;
    waits = 0;
    #1;
    while (obi_rsp.gnt !== 1'b1 && waits < 20) begin
      @(posedge clk);
      #1;
      waits++;
    end
    check($sformatf("gnt_wait_%02h", off), 32'(waits), 32'(exp_waits));
    if (obi_rsp.gnt !== 1'b1) begin
      obi_req = '0;
      @(negedge clk);
      return;
    end
    e.off = off; e.rdata = exp_rdata; e.err = exp_err; e.rid = aid; e.chk_rdata = !we;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    obi_req = '0;
    check($sformatf("rvalid_%02h", off), {31'd0, obi_rsp.rvalid}, 32'd1);
    e = sb.pop_front();
    if (obi_rsp.rvalid === 1'b1) begin
      check($sformatf("rid_%02h", e.off), {28'd0, obi_rsp.r.rid}, {28'd0, e.rid});
      check($sformatf("err_%02h", e.off), {31'd0, obi_rsp.r.err}, {31'd0, e.err});
      if (e.chk_rdata) check($sformatf("rdata_%02h", e.off), obi_rsp.r.rdata, e.rdata);
    end
    $display("txn %s off=0x%02h wdata=0x%08h rdata=0x%08h err=%0d rid=%0d waits=%0d",
             we ? "WR" : "RD", off, wdata, obi_rsp.r.rdata, obi_rsp.r.err, obi_rsp.r.rid, waits);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_rvalid", {31'd0, obi_rsp.rvalid}, 32'd0);
      check("idle_gnt", {31'd0, obi_rsp.gnt}, 32'd0);
    end
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    fail_cnt  = 0;
    aid_ctr   = 4'd1;
    obi_req   = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rvalid", {31'd0, obi_rsp.rvalid}, 32'd0);
    check("reset_rdata", obi_rsp.r.rdata, 32'd0);
    rst_n = 1'b1;
    idle_check(1);

    // Reset values, back-to-back reads with no stall
    access(1'b0, 8'h00, 32'd0, 32'h0, 1'b0, 0);
    access(1'b0, 8'h08, 32'd0, 32'h0, 1'b0, 0);
    for (int c = 0; c < 4; c++) access(1'b0, 8'(8'h14 + 8 * c), 32'd0, 32'h0, 1'b0, 0);

    // ADD[0]: 16 set bits, gnt low for 4 cycles of COUNT
    access(1'b1, 8'h10, 32'hFFFF_0000, 32'h0, 1'b0, 0);
    access(1'b0, 8'h14, 32'd0, 32'h10, 1'b0, 4);
    access(1'b0, 8'h08, 32'd0, 32'h0, 1'b0, 0);

    // Wrap mode overflow on channel 1
    access(1'b1, 8'h00, 32'h0, 32'h0, 1'b0, 0);
    access(1'b1, 8'h1C, 32'h0000_FFF0, 32'h0, 1'b0, 0);
    access(1'b1, 8'h18, 32'h0000_FFFF, 32'h0, 1'b0, 0);
    access(1'b0, 8'h1C, 32'd0, 32'h0000, 1'b0, 4);
    access(1'b0, 8'h08, 32'd0, 32'h2, 1'b0, 0);
    access(1'b1, 8'h08, 32'h2, 32'h0, 1'b0, 0);
    access(1'b0, 8'h08, 32'd0, 32'h0, 1'b0, 0);

    // Saturate mode overflow on channel 1
    access(1'b1, 8'h00, 32'h1, 32'h0, 1'b0, 0);
    access(1'b1, 8'h1C, 32'h0000_FFF0, 32'h0, 1'b0, 0);
    access(1'b1, 8'h18, 32'h0000_FFFF, 32'h0, 1'b0, 0);
    access(1'b0, 8'h1C, 32'd0, 32'hFFFF, 1'b0, 4);
    access(1'b0, 8'h08, 32'd0, 32'h2, 1'b0, 0);

    // CLEAR selected channels
    for (int c = 0; c < 4; c++) access(1'b1, 8'(8'h14 + 8 * c), 32'd5, 32'h0, 1'b0, 0);
    access(1'b1, 8'h04, 32'h5, 32'h0, 1'b0, 0);
    access(1'b0, 8'h14, 32'd0, 32'h0, 1'b0, 0);
    access(1'b0, 8'h1C, 32'd0, 32'h5, 1'b0, 0);
    access(1'b0, 8'h24, 32'd0, 32'h0, 1'b0, 0);
    access(1'b0, 8'h2C, 32'd0, 32'h5, 1'b0, 0);

    // Second overflow on channel 3, then W1C bit 1 only
    access(1'b1, 8'h2C, 32'h0000_FFFF, 32'h0, 1'b0, 0);
    access(1'b1, 8'h28, 32'h0000_0001, 32'h0, 1'b0, 0);
    access(1'b0, 8'h08, 32'd0, 32'hA, 1'b0, 4);
    access(1'b1, 8'h08, 32'h2, 32'h0, 1'b0, 0);
    access(1'b0, 8'h08, 32'd0, 32'h8, 1'b0, 0);
    access(1'b0, 8'h2C, 32'd0, 32'hFFFF, 1'b0, 0);

    // Error accesses with no side effect
    access(1'b0, 8'h10, 32'd0, 32'h0, 1'b1, 0);
    access(1'b0, 8'h40, 32'd0, 32'h0, 1'b1, 0);
    access(1'b0, 8'h04, 32'd0, 32'h0, 1'b1, 0);
    access(1'b0, 8'h0C, 32'd0, 32'h0, 1'b1, 0);
    access(1'b1, 8'h40, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    access(1'b1, 8'h0C, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    access(1'b0, 8'h14, 32'd0, 32'h0, 1'b0, 0);
    access(1'b0, 8'h08, 32'd0, 32'h8, 1'b0, 0);

    // busy is read-only
    access(1'b1, 8'h00, 32'h3, 32'h0, 1'b0, 0);
    access(1'b0, 8'h00, 32'd0, 32'h1, 1'b0, 0);

    // Reset during COUNT cycle 2 aborts the job
    access(1'b1, 8'h20, 32'hFFFF_FFFF, 32'h0, 1'b0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(3);
    access(1'b0, 8'h24, 32'd0, 32'h0, 1'b0, 0);
    access(1'b0, 8'h2C, 32'd0, 32'h0, 1'b0, 0);
    access(1'b0, 8'h00, 32'd0, 32'h0, 1'b0, 0);
    access(1'b0, 8'h08, 32'd0, 32'h0, 1'b0, 0);
    idle_check(1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
